write_to_ddr3: RTL and testbench

//  Avalon-MM burst write master filling the DDR3 double frame buffer.

---
 rtl/write_to_ddr3.sv | 243 ++++++++++++++++++++++++
 tb/tb_write_to_ddr3.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_to_ddr3.sv
// write_to_ddr3: Avalon-MM burst write master for the DDR3 double frame buffer.
// Drains the show-ahead pixel FIFO into buffer0/buffer1 in 4-beat bursts,
// pulses bufferN_filled when a frame completes, and services single-beat
// debug test writes between bursts.
// Optional build macro DDR3_WR_STATS_EN adds stall_cycles / frames_written.
module write_to_ddr3 #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 1024,
    parameter int FIFO_USED_W  = 9
) (
    input  logic                   ddr3_clk,
    input  logic                   ddr3_reset,
    input  logic [25:0]            ddr3_buffer0_offset,
    input  logic [25:0]            ddr3_buffer1_offset,
    input  logic                   ddr3_wr_buffer0_free,
    input  logic                   ddr3_wr_buffer1_free,
    output logic                   buffer0_filled,
    output logic                   buffer1_filled,
    input  logic [127:0]           fifo_rd_data,
    input  logic [FIFO_USED_W-1:0] fifo_used,
    output logic                   fifo_rd_ack,
    input  logic                   test_wr,
    input  logic [31:0]            test_addr,
    input  logic [127:0]           test_wr_data,
    output logic                   wr_finish,
    input  logic                   ddr3_avl_ready,
    output logic                   ddr3_avl_burstbegin,
    output logic                   ddr3_avl_write_req,
    output logic [2:0]             ddr3_avl_size,
    output logic [25:0]            ddr3_avl_addr,
    output logic [127:0]           ddr3_avl_wdata,
    output logic [15:0]            ddr3_avl_be
`ifdef DDR3_WR_STATS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [15:0]            frames_written
`endif
);

    localparam logic [23:0] MAX_COUNT = 24'(((IMAGE_WIDTH * IMAGE_HEIGHT) >> 4) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST_WRITE,
        S_FRAME_START,
        S_BURST,
        S_WAIT_DATA
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [25:0]   r_addr;
    logic [2:0]    r_size;
    logic [25:0]   r_frame_addr;
    logic [2:0]    r_frame_size;
    logic          r_buf_sel;
    logic          r_in_frame;
    logic [23:0]   r_count;
    logic [1:0]    r_beat;
    logic          r_test_pending;
    logic [25:0]   r_test_addr;
    logic [127:0]  r_test_data;
    logic          r_buf0_filled;
    logic          r_buf1_filled;
    logic          r_wr_finish;

    logic          w_accept;
    logic          w_buf_free;
    logic          w_fifo_ready;
    logic          w_burst_done;
    logic          w_test_done;
    logic [5:0]    w_unused_test_addr_hi;

    assign w_unused_test_addr_hi = test_addr[31:26];

    assign w_accept     = ((r_state == S_BURST) || (r_state == S_TEST_WRITE)) && ddr3_avl_ready;
    assign w_buf_free   = r_buf_sel ? ddr3_wr_buffer1_free : ddr3_wr_buffer0_free;
    assign w_fifo_ready = (fifo_used >= FIFO_USED_W'(4));
    assign w_burst_done = (r_state == S_BURST) && w_accept && (r_beat == 2'd3);
    assign w_test_done  = (r_state == S_TEST_WRITE) && w_accept;

    assign ddr3_avl_size  = r_size;
    assign ddr3_avl_addr  = r_addr;
    assign ddr3_avl_be    = '1;
    assign buffer0_filled = r_buf0_filled;
    assign buffer1_filled = r_buf1_filled;
    assign wr_finish      = r_wr_finish;

    // State register
    always_ff @(posedge ddr3_clk or posedge ddr3_reset) begin
        if (ddr3_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and Avalon request/data outputs
    always_comb begin
        w_next              = r_state;
        ddr3_avl_write_req  = 1'b0;
        ddr3_avl_burstbegin = 1'b0;
        ddr3_avl_wdata      = fifo_rd_data;
        fifo_rd_ack         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_test_pending) begin
                    w_next = S_TEST_WRITE;
                end else if (r_in_frame) begin
                    w_next = S_WAIT_DATA;
                end else if (w_buf_free) begin
                    w_next = S_FRAME_START;
                end
            end
            S_FRAME_START: w_next = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (r_test_pending) begin
                    w_next = S_IDLE;
                end else if (w_fifo_ready) begin
                    w_next = S_BURST;
                end
            end
            S_BURST: begin
                ddr3_avl_write_req  = 1'b1;
                ddr3_avl_burstbegin = (r_beat == 2'd0);
                fifo_rd_ack         = ddr3_avl_ready;
                if (w_burst_done) begin
                    w_next = S_IDLE;
                end
            end
            S_TEST_WRITE: begin
                ddr3_avl_write_req  = 1'b1;
                ddr3_avl_burstbegin = 1'b1;
                ddr3_avl_wdata      = r_test_data;
                if (w_test_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Frame/burst bookkeeping, test-write capture and completion pulses.
    // The Avalon addr/size registers are borrowed by a test write and then
    // restored from the frame shadow copies so the frame resumes in place.
    always_ff @(posedge ddr3_clk or posedge ddr3_reset) begin
        if (ddr3_reset) begin
            r_addr         <= '0;
            r_size         <= '0;
            r_frame_addr   <= '0;
            r_frame_size   <= '0;
            r_buf_sel      <= 1'b0;
            r_in_frame     <= 1'b0;
            r_count        <= '0;
            r_beat         <= '0;
            r_test_pending <= 1'b0;
            r_test_addr    <= '0;
            r_test_data    <= '0;
            r_buf0_filled  <= 1'b0;
            r_buf1_filled  <= 1'b0;
            r_wr_finish    <= 1'b0;
        end else begin
            r_buf0_filled <= 1'b0;
            r_buf1_filled <= 1'b0;
            r_wr_finish   <= 1'b0;

            if (w_test_done) begin
                r_test_pending <= 1'b0;
            end else if (test_wr && !r_test_pending) begin
                r_test_pending <= 1'b1;
                r_test_addr    <= test_addr[25:0];
                r_test_data    <= test_wr_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_test_pending) begin
                        r_addr <= r_test_addr;
                        r_size <= 3'b001;
                    end
                end
                S_FRAME_START: begin
                    r_addr       <= r_buf_sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
                    r_frame_addr <= r_buf_sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
                    r_size       <= 3'b100;
                    r_frame_size <= 3'b100;
                    r_count      <= '0;
                    r_in_frame   <= 1'b1;
                end
                S_BURST: begin
                    if (w_accept) begin
                        r_beat <= r_beat + 2'd1;
                        if (r_beat == 2'd3) begin
                            if (r_count == MAX_COUNT) begin
                                r_buf0_filled <= ~r_buf_sel;
                                r_buf1_filled <= r_buf_sel;
                                r_buf_sel     <= ~r_buf_sel;
                                r_in_frame    <= 1'b0;
                            end else begin
                                r_addr       <= r_frame_addr + 26'd4;
                                r_frame_addr <= r_frame_addr + 26'd4;
                                r_count      <= r_count + 24'd1;
                            end
                        end
                    end
                end
                S_TEST_WRITE: begin
                    if (w_accept) begin
                        r_wr_finish <= 1'b1;
                        r_addr      <= r_frame_addr;
                        r_size      <= r_frame_size;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DDR3_WR_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_frames_written;

    assign stall_cycles   = r_stall_cycles;
    assign frames_written = r_frames_written;

    // Saturating stall counter and wrapping completed-frame counter
    always_ff @(posedge ddr3_clk or posedge ddr3_reset) begin
        if (ddr3_reset) begin
            r_stall_cycles   <= '0;
            r_frames_written <= '0;
        end else begin
            if (ddr3_avl_write_req && !ddr3_avl_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (r_buf0_filled || r_buf1_filled) begin
                r_frames_written <= r_frames_written + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_write_to_ddr3.sv
// Self-checking bench for write_to_ddr3 (8x4 image => two bursts per frame).
// Accepted Avalon beats are checked against a queue of expected beats that
// the stimulus tasks push; filled/finish pulses are checked one cycle after
// the beat that should produce them.
module tb_write_to_ddr3;

    localparam logic [25:0] OFF0 = 26'h0001000;
    localparam logic [25:0] OFF1 = 26'h3FFFFFC;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         free0 = 1'b0;
    logic         free1 = 1'b0;
    logic         buffer0_filled, buffer1_filled;
    logic [127:0] fifo_rd_data = '0;
    logic [8:0]   fifo_used = '0;
    logic         fifo_rd_ack;
    logic         test_wr = 1'b0;
    logic [31:0]  test_addr = '0;
    logic [127:0] test_wr_data = '0;
    logic         wr_finish;
    logic         avl_ready = 1'b1;
    logic         avl_bb, avl_wreq;
    logic [2:0]   avl_size;
    logic [25:0]  avl_addr;
    logic [127:0] avl_wdata;
    logic [15:0]  avl_be;

    always #5 clk = ~clk;

    write_to_ddr3 #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(4), .FIFO_USED_W(9)) dut (
        .ddr3_clk(clk), .ddr3_reset(rst),
        .ddr3_buffer0_offset(OFF0), .ddr3_buffer1_offset(OFF1),
        .ddr3_wr_buffer0_free(free0), .ddr3_wr_buffer1_free(free1),
        .buffer0_filled(buffer0_filled), .buffer1_filled(buffer1_filled),
        .fifo_rd_data(fifo_rd_data), .fifo_used(fifo_used), .fifo_rd_ack(fifo_rd_ack),
        .test_wr(test_wr), .test_addr(test_addr), .test_wr_data(test_wr_data),
        .wr_finish(wr_finish),
        .ddr3_avl_ready(avl_ready), .ddr3_avl_burstbegin(avl_bb),
        .ddr3_avl_write_req(avl_wreq), .ddr3_avl_size(avl_size),
        .ddr3_avl_addr(avl_addr), .ddr3_avl_wdata(avl_wdata), .ddr3_avl_be(avl_be)
    );

    typedef struct {
        logic [25:0]  addr;
        logic [127:0] data;
        logic [2:0]   size;
        logic         bb;
        logic         ack;
        logic         f0;
        logic         f1;
        logic         fin;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    logic [127:0] fifo_q[$];
    logic [127:0] held_q[$];
    logic [127:0] dummy;
    int n_checks = 0;
    int n_fail   = 0;
    int n_acks   = 0;
    int cnt_f0   = 0;
    int cnt_f1   = 0;
    int cnt_fin  = 0;
    logic ack_s   = 1'b0;
    logic exp_f0  = 1'b0;
    logic exp_f1  = 1'b0;
    logic exp_fin = 1'b0;

    task automatic refresh_fifo();
        fifo_used    = 9'(fifo_q.size());
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [127:0] d);
        fifo_q.push_back(d);
        refresh_fifo();
    endtask

    // Queue four expected beats at address a; only the first n words enter the FIFO now.
    task automatic add_burst(input logic [25:0] a, input logic f0, input logic f1, input int n);
        exp_t x;
        for (int i = 0; i < 4; i++) begin
            x.addr = a;
            x.data = {$urandom, $urandom, $urandom, $urandom};
            x.size = 3'b100;
            x.bb   = (i == 0);
            x.ack  = 1'b1;
            x.f0   = (i == 3) && f0;
            x.f1   = (i == 3) && f1;
            x.fin  = 1'b0;
            exp_q.push_back(x);
            if (i < n) push_word(x.data);
            else held_q.push_back(x.data);
        end
    endtask

    task automatic release_held();
        while (held_q.size() > 0) push_word(held_q.pop_front());
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Show-ahead FIFO model: pop on a beat acknowledged in the cycle just ended
    always @(posedge clk) begin
        #1;
        if (ack_s) begin
            if (fifo_q.size() > 0) dummy = fifo_q.pop_front();
            n_acks++;
            refresh_fifo();
        end
    end

    // Scoreboard: compare each accepted beat and the pulses that follow it
    always @(negedge clk) begin
        ack_s = fifo_rd_ack;
        if (buffer0_filled) cnt_f0++;
        if (buffer1_filled) cnt_f1++;
        if (wr_finish) cnt_fin++;
        if (exp_f0 || buffer0_filled) begin
            n_checks++;
            if (buffer0_filled !== exp_f0) begin
                n_fail++;
                $display("FAIL buffer0_filled_pulse: got %b expected %b at %0t", buffer0_filled, exp_f0, $time);
            end
        end
        if (exp_f1 || buffer1_filled) begin
            n_checks++;
            if (buffer1_filled !== exp_f1) begin
                n_fail++;
                $display("FAIL buffer1_filled_pulse: got %b expected %b at %0t", buffer1_filled, exp_f1, $time);
            end
        end
        if (exp_fin || wr_finish) begin
            n_checks++;
            if (wr_finish !== exp_fin) begin
                n_fail++;
                $display("FAIL wr_finish_pulse: got %b expected %b at %0t", wr_finish, exp_fin, $time);
            end
        end
        exp_f0  = 1'b0;
        exp_f1  = 1'b0;
        exp_fin = 1'b0;
        if (avl_wreq === 1'b1 && avl_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got addr=%h data=%h, expected no beat", avl_addr, avl_wdata);
            end else begin
                e = exp_q.pop_front();
                if (avl_addr !== e.addr || avl_wdata !== e.data || avl_size !== e.size ||
                    avl_bb !== e.bb || fifo_rd_ack !== e.ack) begin
                    n_fail++;
                    $display("FAIL beat: got addr=%h size=%0d bb=%b ack=%b data=%h, expected addr=%h size=%0d bb=%b ack=%b data=%h",
                             avl_addr, avl_size, avl_bb, fifo_rd_ack, avl_wdata,
                             e.addr, e.size, e.bb, e.ack, e.data);
                end
                exp_f0  = e.f0;
                exp_f1  = e.f1;
                exp_fin = e.fin;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        @(negedge clk);
        n_checks++;
        if ({avl_wreq, avl_bb, fifo_rd_ack, buffer0_filled, buffer1_filled, wr_finish, avl_size, avl_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wreq=%b bb=%b ack=%b f0=%b f1=%b fin=%b size=%0d addr=%h, expected all 0",
                     avl_wreq, avl_bb, fifo_rd_ack, buffer0_filled, buffer1_filled, wr_finish, avl_size, avl_addr);
        end
        n_checks++;
        if (avl_be !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL byte_enable: got %h expected ffff", avl_be);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(4);
        n_checks++;
        if (avl_wreq !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_free_buffer: got wreq=%b expected 0", avl_wreq);
        end
    endtask

    task automatic test_frame_basic();
        int base, t;
        base  = n_acks;
        free0 = 1'b1;
        add_burst(OFF0, 1'b0, 1'b0, 4);
        add_burst(OFF0 + 26'd4, 1'b1, 1'b0, 4);
        t = 0;
        while (cnt_f0 < 1 && t < 100) begin cyc(1); t++; end
        cyc(2);
        n_checks++;
        if (cnt_f0 !== 1 || cnt_f1 !== 0) begin
            n_fail++;
            $display("FAIL frame0_filled: got f0=%0d f1=%0d expected 1 0", cnt_f0, cnt_f1);
        end
        n_checks++;
        if (n_acks - base !== 8) begin
            n_fail++;
            $display("FAIL frame0_acks: got %0d expected 8", n_acks - base);
        end
        // buffer1 not yet released: data waits, nothing is written
        add_burst(OFF1, 1'b0, 1'b0, 4);
        cyc(20);
        n_checks++;
        if (n_acks - base !== 8 || avl_wreq !== 1'b0) begin
            n_fail++;
            $display("FAIL buffer1_busy_hold: got acks=%0d wreq=%b expected 8 0", n_acks - base, avl_wreq);
        end
        free1 = 1'b1;
        t = 0;
        while (n_acks - base < 12 && t < 50) begin cyc(1); t++; end
        cyc(2);
        n_checks++;
        if (n_acks - base !== 12 || cnt_f1 !== 0) begin
            n_fail++;
            $display("FAIL frame1_first_burst: got acks=%0d f1=%0d expected 12 0", n_acks - base, cnt_f1);
        end
    endtask

    task automatic test_partial_fifo();
        int base, t;
        base = n_acks;
        add_burst(OFF1 + 26'd4, 1'b0, 1'b1, 3);
        cyc(15);
        n_checks++;
        if (n_acks !== base || avl_wreq !== 1'b0) begin
            n_fail++;
            $display("FAIL three_words_no_request: got acks=%0d wreq=%b expected 0 0", n_acks - base, avl_wreq);
        end
        release_held();
        t = 0;
        while (cnt_f1 < 1 && t < 50) begin cyc(1); t++; end
        cyc(2);
        n_checks++;
        if (n_acks - base !== 4 || cnt_f1 !== 1) begin
            n_fail++;
            $display("FAIL fourth_word_burst: got acks=%0d f1=%0d expected 4 1", n_acks - base, cnt_f1);
        end
    endtask

    task automatic test_stall();
        int base, t;
        exp_t hold;
        base = n_acks;
        add_burst(OFF0, 1'b0, 1'b0, 4);
        t = 0;
        while (n_acks - base < 2 && t < 50) begin cyc(1); t++; end
        avl_ready = 1'b0;
        hold = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (avl_wreq !== 1'b1 || fifo_rd_ack !== 1'b0 || avl_addr !== hold.addr || avl_wdata !== hold.data) begin
                n_fail++;
                $display("FAIL stall_hold: got wreq=%b ack=%b addr=%h data=%h expected 1 0 %h %h",
                         avl_wreq, fifo_rd_ack, avl_addr, avl_wdata, hold.addr, hold.data);
            end
            @(posedge clk);
            #2;
        end
        avl_ready = 1'b1;
        t = 0;
        while (n_acks - base < 4 && t < 50) begin cyc(1); t++; end
        cyc(3);
        n_checks++;
        if (n_acks - base !== 4) begin
            n_fail++;
            $display("FAIL stall_ack_count: got %0d expected 4", n_acks - base);
        end
        add_burst(OFF0 + 26'd4, 1'b1, 1'b0, 4);
        t = 0;
        while (cnt_f0 < 2 && t < 50) begin cyc(1); t++; end
        cyc(2);
        n_checks++;
        if (cnt_f0 !== 2) begin
            n_fail++;
            $display("FAIL frame2_filled: got %0d expected 2", cnt_f0);
        end
    endtask

    task automatic test_test_write();
        int base, fin0, t;
        exp_t x;
        base = n_acks;
        fin0 = cnt_fin;
        add_burst(OFF1, 1'b0, 1'b0, 4);
        t = 0;
        while (n_acks - base < 1 && t < 50) begin cyc(1); t++; end
        test_wr      = 1'b1;
        test_addr    = 32'hFC00_0100;
        test_wr_data = {16{8'hA5}};
        x.addr = 26'h0000100;
        x.data = {16{8'hA5}};
        x.size = 3'b001;
        x.bb   = 1'b1;
        x.ack  = 1'b0;
        x.f0   = 1'b0;
        x.f1   = 1'b0;
        x.fin  = 1'b1;
        exp_q.push_back(x);
        cyc(1);
        // second request while the first is still pending must be dropped
        test_addr    = 32'h0000_0200;
        test_wr_data = {16{8'h5A}};
        cyc(1);
        test_wr = 1'b0;
        t = 0;
        while (cnt_fin < fin0 + 1 && t < 50) begin cyc(1); t++; end
        cyc(2);
        n_checks++;
        if (cnt_fin - fin0 !== 1 || n_acks - base !== 4) begin
            n_fail++;
            $display("FAIL test_write_done: got finish=%0d acks=%0d expected 1 4", cnt_fin - fin0, n_acks - base);
        end
        add_burst(OFF1 + 26'd4, 1'b0, 1'b1, 4);
        t = 0;
        while (cnt_f1 < 2 && t < 50) begin cyc(1); t++; end
        cyc(4);
        n_checks++;
        if (cnt_f1 !== 2 || cnt_fin - fin0 !== 1) begin
            n_fail++;
            $display("FAIL frame3_resume: got f1=%0d finish=%0d expected 2 1", cnt_f1, cnt_fin - fin0);
        end
    endtask

    task automatic test_reset_mid();
        int base, t, f0b, f1b;
        exp_t x;
        add_burst(OFF0, 1'b0, 1'b0, 4);
        add_burst(OFF0 + 26'd4, 1'b1, 1'b0, 4);
        t = 0;
        while (cnt_f0 < 3 && t < 80) begin cyc(1); t++; end
        cyc(2);
        base = n_acks;
        add_burst(OFF1, 1'b0, 1'b0, 4);
        t = 0;
        while (n_acks - base < 2 && t < 50) begin cyc(1); t++; end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({avl_wreq, avl_bb, fifo_rd_ack, avl_size, avl_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_burst: got wreq=%b bb=%b ack=%b size=%0d addr=%h expected all 0",
                     avl_wreq, avl_bb, fifo_rd_ack, avl_size, avl_addr);
        end
        exp_q.delete();
        f0b = cnt_f0;
        f1b = cnt_f1;
        cyc(2);
        rst = 1'b0;
        n_checks++;
        if (fifo_q.size() !== 2) begin
            n_fail++;
            $display("FAIL leftover_words: got %0d expected 2", fifo_q.size());
        end else begin
            // restart lands in buffer0, consuming the two words left in the FIFO first
            for (int i = 0; i < 4; i++) begin
                x.addr = OFF0;
                x.data = (i < 2) ? fifo_q[i] : {$urandom, $urandom, $urandom, $urandom};
                x.size = 3'b100;
                x.bb   = (i == 0);
                x.ack  = 1'b1;
                x.f0   = 1'b0;
                x.f1   = 1'b0;
                x.fin  = 1'b0;
                exp_q.push_back(x);
                if (i >= 2) push_word(x.data);
            end
        end
        t = 0;
        while (n_acks - base < 6 && t < 50) begin cyc(1); t++; end
        cyc(3);
        n_checks++;
        if (n_acks - base !== 6 || cnt_f0 !== f0b || cnt_f1 !== f1b || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL restart_after_reset: got acks=%0d f0+%0d f1+%0d left=%0d expected 6 0 0 0",
                     n_acks - base, cnt_f0 - f0b, cnt_f1 - f1b, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_partial_fifo();
        test_stall();
        test_test_write();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL beats_outstanding: got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
